// File: rtl/i2c_master_rw.sv
// I2C master: one START / address+R/W / N data bytes / STOP transaction per command.
// Open-drain pads: *_oe=1 pulls the line low, 0 releases it.
module i2c_master_rw #(
    parameter int unsigned DIV   = 4,
    parameter int unsigned LEN_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [6:0]       addr,
    input  logic             rw,
    input  logic [LEN_W-1:0] len,
    input  logic [7:0]       tx_data,
    output logic             tx_req,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic             done,
    output logic             ack_err,
    output logic             scl_oe,
    output logic             sda_oe,
    input  logic             sda_in
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_ADDR_ACK,
        S_WR_BYTE,
        S_WR_ACK,
        S_RD_BYTE,
        S_RD_ACK,
        S_STOP
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] div_cnt;
    logic [1:0]       quarter;
    logic [2:0]       bit_cnt;
    logic [7:0]       tx_sr;
    logic [6:0]       rx_sr;
    logic [LEN_W-1:0] len_cnt;
    logic             rw_q;
    logic             ack_bit;

    logic accept;
    logic q_end;
    logic bit_end;
    logic byte_end;
    logic sample;
    logic first_byte_clk;
    logic last_byte;
    logic byte_state;

    assign accept         = start && (state == S_IDLE);
    assign q_end          = (div_cnt == CNT_W'(DIV - 1));
    assign bit_end        = q_end && (quarter == 2'd3);
    assign byte_end       = bit_end && (bit_cnt == 3'd7);
    assign sample         = q_end && (quarter == 2'd2);
    assign first_byte_clk = (div_cnt == '0) && (quarter == 2'd0) && (bit_cnt == 3'd0);
    assign last_byte      = (len_cnt == LEN_W'(1));
    assign byte_state     = (state == S_ADDR) || (state == S_WR_BYTE) || (state == S_RD_BYTE);

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    // Next-state: every non-idle state advances only on a bit boundary
    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:     if (accept)   state_n = S_START;
            S_START:    if (bit_end)  state_n = S_ADDR;
            S_ADDR:     if (byte_end) state_n = S_ADDR_ACK;
            S_ADDR_ACK: if (bit_end) begin
                if (ack_bit || (len_cnt == '0)) state_n = S_STOP;
                else if (rw_q)                  state_n = S_RD_BYTE;
                else                            state_n = S_WR_BYTE;
            end
            S_WR_BYTE:  if (byte_end) state_n = S_WR_ACK;
            S_WR_ACK:   if (bit_end) begin
                if (ack_bit || last_byte) state_n = S_STOP;
                else                      state_n = S_WR_BYTE;
            end
            S_RD_BYTE:  if (byte_end) state_n = S_RD_ACK;
            S_RD_ACK:   if (bit_end) begin
                if (last_byte) state_n = S_STOP;
                else           state_n = S_RD_BYTE;
            end
            S_STOP:     if (bit_end)  state_n = S_IDLE;
            default:                  state_n = S_IDLE;
        endcase
    end

    // Quarter-period timing: DIV clks per quarter, 4 quarters per bit, 8 bits per byte
    always_ff @(posedge clk) begin
        if (reset || (state == S_IDLE)) begin
            div_cnt <= '0;
            quarter <= 2'd0;
            bit_cnt <= 3'd0;
        end else begin
            if (q_end) begin
                div_cnt <= '0;
                quarter <= quarter + 2'd1;
            end else begin
                div_cnt <= div_cnt + CNT_W'(1);
            end
            if (bit_end && byte_state) bit_cnt <= bit_cnt + 3'd1;
        end
    end

    // Datapath: command latch, shift registers, ACK sampling, byte counter, pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_sr    <= '0;
            rx_sr    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            done     <= 1'b0;
            ack_err  <= 1'b0;
            len_cnt  <= '0;
            rw_q     <= 1'b0;
            ack_bit  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            done     <= (state == S_STOP) && bit_end;

            if (accept) begin
                tx_sr   <= {addr, rw};
                rw_q    <= rw;
                len_cnt <= len;
                ack_err <= 1'b0;
            end

            // The byte is taken from tx_data in the tx_req clk itself, so the
            // first bit on SDA comes straight from tx_data (see sda_oe decode).
            if ((state == S_WR_BYTE) && first_byte_clk)
                tx_sr <= tx_data;
            else if (((state == S_ADDR) || (state == S_WR_BYTE)) && bit_end)
                tx_sr <= {tx_sr[6:0], 1'b0};

            if (((state == S_ADDR_ACK) || (state == S_WR_ACK)) && sample) begin
                ack_bit <= sda_in;
                if (sda_in) ack_err <= 1'b1;
            end

            if ((state == S_RD_BYTE) && sample) begin
                rx_sr <= {rx_sr[5:0], sda_in};
                if (bit_cnt == 3'd7) begin
                    rx_data  <= {rx_sr, sda_in};
                    rx_valid <= 1'b1;
                end
            end

            if ((((state == S_WR_ACK) && !ack_bit) || (state == S_RD_ACK)) && bit_end
                && (len_cnt != '0))
                len_cnt <= len_cnt - LEN_W'(1);
        end
    end

    // Pad and handshake decode from the current state and quarter
    always_comb begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
        tx_req = 1'b0;
        busy   = (state != S_IDLE);
        unique case (state)
            S_IDLE: ;
            S_START: begin
                scl_oe = (quarter == 2'd3);
                sda_oe = quarter[1];
            end
            S_ADDR: begin
                scl_oe = ~quarter[1];
                sda_oe = ~tx_sr[7];
            end
            S_ADDR_ACK, S_WR_ACK, S_RD_BYTE: begin
                scl_oe = ~quarter[1];
            end
            S_WR_BYTE: begin
                scl_oe = ~quarter[1];
                tx_req = first_byte_clk;
                sda_oe = first_byte_clk ? ~tx_data[7] : ~tx_sr[7];
            end
            S_RD_ACK: begin
                scl_oe = ~quarter[1];
                sda_oe = ~last_byte;
            end
            S_STOP: begin
                scl_oe = ~quarter[1];
                sda_oe = (quarter != 2'd3) || (div_cnt < CNT_W'(DIV / 2));
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_i2c_master_rw.sv
// Directed bench for i2c_master_rw with an I2C slave model, bus monitor and scoreboard.
module tb_i2c_master_rw;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [6:0] addr;
    logic       rw;
    logic [3:0] len;
    logic [7:0] tx_data = 8'h00;
    logic       tx_req;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic       scl_oe;
    logic       sda_oe;
    logic       sda_slv = 1'b1;
    logic       sda_line;

    assign sda_line = ~sda_oe & sda_slv;

    i2c_master_rw #(.DIV(4), .LEN_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .addr     (addr),
        .rw       (rw),
        .len      (len),
        .tx_data  (tx_data),
        .tx_req   (tx_req),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .busy     (busy),
        .done     (done),
        .ack_err  (ack_err),
        .scl_oe   (scl_oe),
        .sda_oe   (sda_oe),
        .sda_in   (sda_line)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;

    // scoreboard queues: {byte, 9th-bit line level} per frame, received bytes, bytes to send
    logic [8:0]  exp_frame_q[$];
    logic [7:0]  exp_rx_q[$];
    logic [7:0]  tx_src_q[$];

    // slave model configuration (written by the stimulus only)
    bit          mon_en = 1'b0;
    bit          slv_abort = 1'b0;
    bit          slv_read = 1'b0;
    int          slv_nack_frame = -1;
    int          slv_nbytes = 0;
    logic [7:0]  slv_bytes[4];

    // monitor state and event counters
    logic        mscl, msda, scl_p = 1'b1, sda_p = 1'b1, busy_p = 1'b0;
    logic [8:0]  cur = '0;
    int          bitpos = 0;
    int          frame = 0;
    int unsigned done_cnt = 0, stop_cnt = 0, rx_cnt = 0, tx_req_cnt = 0;
    int unsigned busy_run = 0, last_busy = 0;
    logic [7:0]  dummy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bus monitor + slave: decode START/STOP/bits on the wire, drive ACKs and read data
    always @(negedge clk) begin
        mscl = ~scl_oe;
        msda = sda_line;
        if (mon_en) begin
            if (scl_p && mscl && sda_p && !msda) begin
                bitpos = 0;
                frame  = 0;
            end else if (scl_p && mscl && !sda_p && msda) begin
                stop_cnt++;
                bitpos = 0;
            end else if (!scl_p && mscl) begin
                cur = {cur[7:0], msda};
                bitpos++;
                if (bitpos == 9) begin
                    if (exp_frame_q.size() == 0) check("frame_extra", {23'd0, cur}, 32'hFFFF);
                    else check("frame", {23'd0, cur}, {23'd0, exp_frame_q.pop_front()});
                    bitpos = 0;
                    frame++;
                end
            end else if (scl_p && !mscl) begin
                if (slv_abort)
                    sda_slv = 1'b1;
                else if (bitpos == 8)
                    sda_slv = (frame == 0 || !slv_read) ? (frame == slv_nack_frame) : 1'b1;
                else if (slv_read && frame >= 1 && frame <= slv_nbytes)
                    sda_slv = slv_bytes[frame-1][7-bitpos];
                else
                    sda_slv = 1'b1;
            end
            if (slv_abort) sda_slv = 1'b1;
        end
        scl_p = mscl;
        sda_p = sda_line;

        if (done === 1'b1) done_cnt++;
        if (rx_valid === 1'b1) begin
            rx_cnt++;
            if (exp_rx_q.size() == 0) check("rx_extra", {24'd0, rx_data}, 32'hFFFF);
            else check("rx_data", {24'd0, rx_data}, {24'd0, exp_rx_q.pop_front()});
        end
        if (busy === 1'b1 && busy_p !== 1'b1) busy_run = 1;
        else if (busy === 1'b1) busy_run++;
        if (busy_p === 1'b1 && busy === 1'b0) last_busy = busy_run;
        busy_p = busy;
    end

    // Write-data source: present the queue head, consume it after the tx_req clk
    always begin
        @(negedge clk);
        if (tx_req === 1'b1) begin
            tx_req_cnt++;
            @(posedge clk);
            #1;
            if (tx_src_q.size() != 0) dummy = tx_src_q.pop_front();
        end
        tx_data = (tx_src_q.size() != 0) ? tx_src_q[0] : 8'h00;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input logic [6:0] a, input logic r, input logic [3:0] l);
        addr  = a;
        rw    = r;
        len   = l;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int unsigned base;
        int unsigned n;
        base = done_cnt;
        n = 0;
        while (done_cnt == base && n < 6000) begin
            step();
            n++;
        end
        check({tag, "_done"}, done_cnt - base, 1);
    endtask

    int unsigned b_tx, b_done, b_stop, b_rx;
    int unsigned n;

    task automatic snap();
        b_tx   = tx_req_cnt;
        b_done = done_cnt;
        b_stop = stop_cnt;
        b_rx   = rx_cnt;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; addr = '0; rw = 1'b0; len = '0;
        repeat (3) step();
        check("rst_scl_oe", scl_oe, 0);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_tx_req", tx_req, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_ack_err", ack_err, 0);
        reset = 1'b0;
        step();
        mon_en = 1'b1;
        step();

        // 1: single-byte write, slave ACKs
        exp_frame_q.push_back({8'hA0, 1'b0});
        exp_frame_q.push_back({8'hA5, 1'b0});
        tx_src_q.push_back(8'hA5);
        step();
        snap();
        issue(7'h50, 1'b0, 4'd1);
        check("t1_busy_rise", busy, 1);
        wait_done("t1");
        check("t1_tx_req", tx_req_cnt - b_tx, 1);
        check("t1_busy_len", last_busy, 320);
        check("t1_ack_err", ack_err, 0);
        check("t1_stop", stop_cnt - b_stop, 1);
        check("t1_frames_left", exp_frame_q.size(), 0);

        // 2: address NACK
        slv_nack_frame = 0;
        exp_frame_q.push_back({8'h54, 1'b1});
        step();
        snap();
        issue(7'h2A, 1'b0, 4'd3);
        wait_done("t2");
        check("t2_ack_err", ack_err, 1);
        check("t2_tx_req", tx_req_cnt - b_tx, 0);
        check("t2_busy_len", last_busy, 176);
        check("t2_stop", stop_cnt - b_stop, 1);
        check("t2_frames_left", exp_frame_q.size(), 0);

        // 3: two-byte read, master ACK then NACK
        slv_nack_frame = -1;
        slv_read = 1'b1; slv_nbytes = 2;
        slv_bytes[0] = 8'h3C; slv_bytes[1] = 8'hC3;
        exp_frame_q.push_back({8'hA1, 1'b0});
        exp_frame_q.push_back({8'h3C, 1'b0});
        exp_frame_q.push_back({8'hC3, 1'b1});
        exp_rx_q.push_back(8'h3C);
        exp_rx_q.push_back(8'hC3);
        step();
        snap();
        issue(7'h50, 1'b1, 4'd2);
        check("t3_ack_err_clr", ack_err, 0);
        wait_done("t3");
        check("t3_rx_count", rx_cnt - b_rx, 2);
        check("t3_busy_len", last_busy, 464);
        check("t3_rx_left", exp_rx_q.size(), 0);
        check("t3_frames_left", exp_frame_q.size(), 0);
        check("t3_rx_hold", rx_data, 8'hC3);

        // 4: three-byte write, slave NACKs byte 2
        slv_read = 1'b0; slv_nbytes = 0;
        slv_nack_frame = 2;
        exp_frame_q.push_back({8'hA0, 1'b0});
        exp_frame_q.push_back({8'h11, 1'b0});
        exp_frame_q.push_back({8'h22, 1'b1});
        tx_src_q.push_back(8'h11);
        tx_src_q.push_back(8'h22);
        tx_src_q.push_back(8'h33);
        step();
        snap();
        issue(7'h50, 1'b0, 4'd3);
        wait_done("t4");
        check("t4_tx_req", tx_req_cnt - b_tx, 2);
        check("t4_ack_err", ack_err, 1);
        check("t4_stop", stop_cnt - b_stop, 1);
        check("t4_frames_left", exp_frame_q.size(), 0);
        tx_src_q.delete();

        // 5: start while busy is ignored; start on the done clk is accepted
        slv_nack_frame = -1;
        exp_frame_q.push_back({8'hA0, 1'b0});
        exp_frame_q.push_back({8'h5A, 1'b0});
        tx_src_q.push_back(8'h5A);
        step();
        snap();
        issue(7'h50, 1'b0, 4'd1);
        check("t5_ack_err_clr", ack_err, 0);
        repeat (100) step();
        issue(7'h11, 1'b1, 4'd5);
        n = 0;
        while (done !== 1'b1 && n < 2000) begin
            step();
            n++;
        end
        check("t5_done_seen", done, 1);
        check("t5_busy_len", last_busy, 320);
        check("t5_tx_req", tx_req_cnt - b_tx, 1);
        exp_frame_q.push_back({8'h66, 1'b0});
        snap();
        issue(7'h33, 1'b0, 4'd0);
        check("t5_b2b_busy", busy, 1);
        wait_done("t5b");
        check("t5b_busy_len", last_busy, 176);
        check("t5b_tx_req", tx_req_cnt - b_tx, 0);
        check("t5_frames_left", exp_frame_q.size(), 0);

        // 6: reset during RD_BYTE bit 4
        slv_read = 1'b1; slv_nbytes = 2;
        slv_bytes[0] = 8'h96; slv_bytes[1] = 8'h69;
        exp_frame_q.push_back({8'hA1, 1'b0});
        step();
        snap();
        issue(7'h50, 1'b1, 4'd2);
        repeat (232) step();
        check("t6_pre_busy", busy, 1);
        slv_abort = 1'b1;
        reset = 1'b1;
        step();
        check("t6_scl_oe", scl_oe, 0);
        check("t6_sda_oe", sda_oe, 0);
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        check("t6_rx_data", rx_data, 0);
        reset = 1'b0;
        repeat (5) step();
        check("t6_no_done", done_cnt - b_done, 0);
        check("t6_no_rx", rx_cnt - b_rx, 0);
        check("t6_frames_left", exp_frame_q.size(), 0);
        slv_abort = 1'b0;
        slv_read = 1'b0; slv_nbytes = 0;

        // 6b: write after reset completes normally
        exp_frame_q.push_back({8'hA0, 1'b0});
        exp_frame_q.push_back({8'hDE, 1'b0});
        exp_frame_q.push_back({8'hAD, 1'b0});
        tx_src_q.push_back(8'hDE);
        tx_src_q.push_back(8'hAD);
        step();
        snap();
        issue(7'h50, 1'b0, 4'd2);
        wait_done("t6b");
        check("t6b_tx_req", tx_req_cnt - b_tx, 2);
        check("t6b_busy_len", last_busy, 464);
        check("t6b_ack_err", ack_err, 0);
        check("t6b_frames_left", exp_frame_q.size(), 0);

        // 7: maximum length write (15 bytes)
        exp_frame_q.push_back({8'hA0, 1'b0});
        for (int i = 0; i < 15; i++) begin
            exp_frame_q.push_back({8'(i * 29 + 3), 1'b0});
            tx_src_q.push_back(8'(i * 29 + 3));
        end
        step();
        snap();
        issue(7'h50, 1'b0, 4'd15);
        wait_done("t7");
        check("t7_tx_req", tx_req_cnt - b_tx, 15);
        check("t7_busy_len", last_busy, 2336);
        check("t7_frames_left", exp_frame_q.size(), 0);
        check("t7_stop", stop_cnt - b_stop, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
